// File: rtl/video_fx_pkg.sv
// Shared definitions for the video effects controller: register map,
// CTRL bit positions, FSM encoding and the effect configuration record.
package video_fx_pkg;

  localparam logic [3:0] ADDR_CTRL     = 4'd0;
  localparam logic [3:0] ADDR_KEY      = 4'd1;
  localparam logic [3:0] ADDR_MASK     = 4'd2;
  localparam logic [3:0] ADDR_SUBST    = 4'd3;
  localparam logic [3:0] ADDR_PERIOD   = 4'd4;
  localparam logic [3:0] ADDR_STATUS   = 4'd5;
  localparam logic [3:0] ADDR_SEQ_BASE = 4'd8;

  localparam int CTRL_EFFECT_LSB = 0;
  localparam int CTRL_DEL_LSB    = 5;
  localparam int CTRL_QUANT_LSB  = 7;
  localparam int CTRL_AUTO_BIT   = 9;
  localparam int CTRL_COMMIT_BIT = 31;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_AUTO    = 2'd2
  } fx_state_e;

  typedef struct packed {
    logic [4:0]  effect;
    logic [1:0]  delete_rgb;
    logic [1:0]  quantif;
    logic        auto_en;
    logic [15:0] key;
    logic [15:0] mask;
    logic [15:0] subst;
  } fx_cfg_t;

  // CTRL readback never reports the self-clearing commit bit.
  function automatic logic [31:0] ctrl_readback(input fx_cfg_t c);
    return {22'd0, c.auto_en, c.quantif, c.delete_rgb, c.effect};
  endfunction

endpackage

// File: rtl/video_fx_regfile.sv
// Avalon-MM slave for the effects controller: decodes writes into the
// shadow registers and returns registered readback one cycle after a read.
module video_fx_regfile
  import video_fx_pkg::*;
#(
  parameter int FRAME_CNT_W = 16,
  parameter int SEQ_LEN     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [3:0]                   avs_address,
  input  logic                         avs_chipselect,
  input  logic                         avs_write,
  input  logic [31:0]                  avs_writedata,
  input  logic                         avs_read,
  output logic [31:0]                  avs_readdata,
  input  logic [31:0]                  status_word,
  output fx_cfg_t                      cfg,
  output logic [FRAME_CNT_W-1:0]       auto_period,
  output logic [SEQ_LEN-1:0][4:0]      seq,
  output logic                         commit_req
);

  fx_cfg_t                    cfg_q, cfg_d;
  logic [FRAME_CNT_W-1:0]     period_q, period_d;
  logic [SEQ_LEN-1:0][4:0]    seq_q, seq_d;
  logic [31:0]                rdata_q, rdata_d;
  logic                       wr_en_s;
  logic                       rd_en_s;
  logic                       unused_wdata_s;

  assign wr_en_s        = avs_chipselect & avs_write;
  assign rd_en_s        = avs_chipselect & avs_read;
  assign unused_wdata_s = ^avs_writedata;
  assign commit_req     = wr_en_s & (avs_address == ADDR_CTRL) & avs_writedata[CTRL_COMMIT_BIT];

  // Shadow register write decode; unmapped addresses leave everything unchanged.
  always_comb begin
    cfg_d    = cfg_q;
    period_d = period_q;
    seq_d    = seq_q;
    if (wr_en_s) begin
      case (avs_address)
        ADDR_CTRL: begin
          cfg_d.effect     = avs_writedata[CTRL_EFFECT_LSB +: 5];
          cfg_d.delete_rgb = avs_writedata[CTRL_DEL_LSB +: 2];
          cfg_d.quantif    = avs_writedata[CTRL_QUANT_LSB +: 2];
          cfg_d.auto_en    = avs_writedata[CTRL_AUTO_BIT];
        end
        ADDR_KEY:    cfg_d.key   = avs_writedata[15:0];
        ADDR_MASK:   cfg_d.mask  = avs_writedata[15:0];
        ADDR_SUBST:  cfg_d.subst = avs_writedata[15:0];
        ADDR_PERIOD: period_d    = avs_writedata[FRAME_CNT_W-1:0];
        default: begin
          for (int i = 0; i < SEQ_LEN; i++) begin
            if (avs_address == ADDR_SEQ_BASE + 4'(i)) seq_d[i] = avs_writedata[4:0];
            else seq_d[i] = seq_q[i];
          end
        end
      endcase
    end else begin
      cfg_d = cfg_q;
    end
  end

  // Readback mux; idle cycles return zero.
  always_comb begin
    rdata_d = 32'd0;
    if (rd_en_s) begin
      case (avs_address)
        ADDR_CTRL:   rdata_d = ctrl_readback(cfg_q);
        ADDR_KEY:    rdata_d = {16'd0, cfg_q.key};
        ADDR_MASK:   rdata_d = {16'd0, cfg_q.mask};
        ADDR_SUBST:  rdata_d = {16'd0, cfg_q.subst};
        ADDR_PERIOD: rdata_d = 32'(period_q);
        ADDR_STATUS: rdata_d = status_word;
        default: begin
          for (int i = 0; i < SEQ_LEN; i++) begin
            if (avs_address == ADDR_SEQ_BASE + 4'(i)) rdata_d = {27'd0, seq_q[i]};
            else rdata_d = rdata_d;
          end
        end
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // Register state for shadows and readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q    <= '0;
      period_q <= '0;
      seq_q    <= '0;
      rdata_q  <= 32'd0;
    end else begin
      cfg_q    <= cfg_d;
      period_q <= period_d;
      seq_q    <= seq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign cfg          = cfg_q;
  assign auto_period  = period_q;
  assign seq          = seq_q;
  assign avs_readdata = rdata_q;

endmodule

// File: rtl/video_effects_ctrl.sv
// Effects controller top: commits shadow settings to the datapath only at
// frame boundaries and optionally steps the effect mask every N frames.
module video_effects_ctrl
  import video_fx_pkg::*;
#(
  parameter int FRAME_CNT_W = 16,
  parameter int SEQ_LEN     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        stream_sop,
  input  logic        stream_valid,
  input  logic        stream_ready,
  output logic [4:0]  effect,
  output logic [1:0]  effect_delete_rgb,
  output logic [1:0]  effect_quantif_level,
  output logic [15:0] effect_color_key,
  output logic [15:0] effect_color_key_mask,
  output logic [15:0] effect_color_substitute,
  output logic        commit_pending,
  output logic        frame_irq
);

  localparam logic [2:0] SEQ_LAST = 3'(SEQ_LEN - 1);

  fx_state_e                 state_q, state_d;
  fx_cfg_t                   act_q, act_d;
  logic [FRAME_CNT_W-1:0]    period_q, period_d;
  logic [FRAME_CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic [2:0]                seq_idx_q, seq_idx_d;
  logic                      irq_q, irq_d;
  logic                      pend_q, pend_d;

  fx_cfg_t                   shadow_s;
  logic [FRAME_CNT_W-1:0]    shadow_period_s;
  logic [SEQ_LEN-1:0][4:0]   seq_s;
  logic                      commit_req_s;
  logic [31:0]               status_s;
  logic                      frame_start_s;
  logic [FRAME_CNT_W-1:0]    period_m1_s;
  logic                      period_hit_s;
  logic [2:0]                seq_next_s;
  logic [4:0]                seq_next_eff_s;
  logic [4:0]                seq_first_eff_s;

  assign frame_start_s = stream_sop & stream_valid & stream_ready;
  assign status_s      = {16'(frame_cnt_q), 11'd0, seq_idx_q, act_q.auto_en, pend_q};

  video_fx_regfile #(
    .FRAME_CNT_W (FRAME_CNT_W),
    .SEQ_LEN     (SEQ_LEN)
  ) u_regfile (
    .clk            (clk),
    .rst_n          (reset),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .status_word    (status_s),
    .cfg            (shadow_s),
    .auto_period    (shadow_period_s),
    .seq            (seq_s),
    .commit_req     (commit_req_s)
  );

  // A programmed period of 0 is treated as 1 frame.
  assign period_m1_s  = (period_q == '0) ? '0 : period_q - FRAME_CNT_W'(1);
  assign period_hit_s = (frame_cnt_q == period_m1_s);
  assign seq_next_s   = (seq_idx_q == SEQ_LAST) ? 3'd0 : seq_idx_q + 3'd1;

  // Sequence table lookup for the next index and for entry 0.
  always_comb begin
    seq_next_eff_s  = 5'd0;
    seq_first_eff_s = seq_s[0];
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (seq_next_s == 3'(i)) seq_next_eff_s = seq_s[i];
      else seq_next_eff_s = seq_next_eff_s;
    end
  end

  // FSM next state, frame counter, sequence stepping and commit.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    period_d    = period_q;
    frame_cnt_d = frame_cnt_q;
    seq_idx_d   = seq_idx_q;
    irq_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_start_s) frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        else frame_cnt_d = frame_cnt_q;
        if (commit_req_s) state_d = ST_PENDING;
        else state_d = ST_IDLE;
      end
      ST_AUTO: begin
        if (frame_start_s && period_hit_s) begin
          frame_cnt_d  = '0;
          seq_idx_d    = seq_next_s;
          act_d.effect = seq_next_eff_s;
        end else if (frame_start_s) begin
          frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end else begin
          frame_cnt_d = frame_cnt_q;
        end
        if (commit_req_s) state_d = ST_PENDING;
        else state_d = ST_AUTO;
      end
      ST_PENDING: begin
        if (frame_start_s) begin
          // The commit uses shadow values as registered before this cycle.
          act_d     = shadow_s;
          period_d  = shadow_period_s;
          irq_d     = 1'b1;
          seq_idx_d = 3'd0;
          if (shadow_s.auto_en) begin
            state_d      = ST_AUTO;
            frame_cnt_d  = '0;
            act_d.effect = seq_first_eff_s;
          end else begin
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
          end
          if (commit_req_s) state_d = ST_PENDING;
          else state_d = state_d;
        end else begin
          state_d = ST_PENDING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = (state_d == ST_PENDING);
  end

  // State, active settings and output pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      act_q       <= '0;
      period_q    <= '0;
      frame_cnt_q <= '0;
      seq_idx_q   <= 3'd0;
      irq_q       <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      period_q    <= period_d;
      frame_cnt_q <= frame_cnt_d;
      seq_idx_q   <= seq_idx_d;
      irq_q       <= irq_d;
      pend_q      <= pend_d;
    end
  end

  assign effect                  = act_q.effect;
  assign effect_delete_rgb       = act_q.delete_rgb;
  assign effect_quantif_level    = act_q.quantif;
  assign effect_color_key        = act_q.key;
  assign effect_color_key_mask   = act_q.mask;
  assign effect_color_substitute = act_q.subst;
  assign commit_pending          = pend_q;
  assign frame_irq               = irq_q;

endmodule

// File: doc/video_effects_ctrl.md
Name: video_effects_ctrl

Overview:
Avalon-MM configuration and scheduling controller for the video effects datapath in the Nios video pipeline. The Nios writes effect settings into shadow registers. The block commits them to the datapath control outputs only at a frame boundary (start-of-packet handshake), so no frame is processed with mixed settings. An optional auto-cycle mode steps the effect mask through a programmed sequence every N frames.

Parameters:
FRAME_CNT_W, 16, width of the frame counter and the auto-cycle period register
SEQ_LEN, 4, number of entries in the auto-cycle effect sequence (max 8)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low (asserted at 0)
avs_address  in  4  register word address
avs_chipselect  in  1  slave select
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_read  in  1  read strobe
avs_readdata  out  32  read data, valid 1 cycle after the read strobe
stream_sop  in  1  startofpacket of the pixel stream entering the datapath
stream_valid  in  1  stream valid
stream_ready  in  1  stream ready
effect  out  5  active effect enables
effect_delete_rgb  out  2  active RGB delete select
effect_quantif_level  out  2  active quantisation level
effect_color_key  out  16  active chroma key
effect_color_key_mask  out  16  active key mask
effect_color_substitute  out  16  active substitute colour
commit_pending  out  1  shadow settings waiting for a frame boundary
frame_irq  out  1  single-cycle pulse on each commit

Behaviour:
- Reset (reset=0): all shadow and active registers are 0, state is IDLE, frame_cnt=0, seq_idx=0, avs_readdata=0, frame_irq=0, auto_period=0. Effects are off, so video passes through.
- frame_start = stream_sop & stream_valid & stream_ready. It is a single-cycle event.
- Register map (word addresses, write when chipselect & write):
  - 0 CTRL: [4:0] effect, [6:5] delete_rgb, [8:7] quantif, [9] auto_en, [31] commit. Writing with bit 31=1 requests a commit.
  - 1 KEY[15:0]
  - 2 MASK[15:0]
  - 3 SUBST[15:0]
  - 4 AUTO_PERIOD[FRAME_CNT_W-1:0], in frames
  - 5 STATUS (read-only): [0] commit_pending, [1] auto_en active, [4:2] seq_idx, [31:16] frame_cnt
  - 8..8+SEQ_LEN-1: SEQ[i][4:0], the effect masks for auto-cycle
  - Unmapped reads return 0. Unmapped writes are ignored.
- Readback: addresses 0-4 return the shadow values with CTRL bit 31 read as 0.
- FSM states:
  - IDLE: on a commit request, go to PENDING.
  - PENDING: commit_pending=1. On frame_start, copy all shadow registers to the active outputs, pulse frame_irq, then go to IDLE.
  - AUTO: entered at the commit of a CTRL with auto_en=1. Each frame_start increments frame_cnt. When frame_cnt==auto_period-1, frame_cnt wraps to 0, seq_idx = (seq_idx+1) mod SEQ_LEN, and the effect output is set to SEQ[new idx]. All other active fields stay as committed.
  - A commit with auto_en=0 returns to IDLE.
  - A commit request in AUTO goes to PENDING; seq_idx is reset to 0 at that commit.
- auto_period=0 behaves as 1: the effect advances every frame.
- frame_cnt counts every frame_start in all states and wraps modulo 2^FRAME_CNT_W. In AUTO it is the period counter and is cleared on entering AUTO.
- Simultaneous commit request and frame_start in IDLE or AUTO: the frame boundary is missed, the state goes to PENDING, and the settings apply at the next frame_start. In AUTO, that frame_start still advances the sequence first.
- Shadow write in the same cycle a PENDING commit fires: the new value is not included in this commit. The commit copies the pre-write shadow.
- A second commit request while PENDING: stay in PENDING; the latest shadow values apply.
- Reset mid-frame: outputs return to 0 immediately (asynchronous).
- Outputs are registered. Latency from frame_start to new active values is exactly 1 clock.

Decomposition:
- Shared package video_fx_pkg: register address constants, CTRL bit-field positions, and FSM state encoding (IDLE/PENDING/AUTO).
- Sub-module video_fx_regfile: Avalon slave decode, shadow registers, readback mux.
- The FSM, frame counter and active registers live in the top module.

Test Plan:
- Write CTRL=0x8000_0011 (effect=5'b10001, commit) with no SOP -> outputs stay 0, commit_pending=1. Drive frame_start -> 1 cycle later effect=5'b10001, frame_irq pulses once, commit_pending=0.
- Write KEY=0x07E0, MASK=0xFFE0, SUBST=0xF800 and commit, then write KEY=0x001F before the SOP -> at SOP the active key is 0x001F (latest shadow wins).
- SEQ[0..3]=0x01,0x02,0x04,0x10; AUTO_PERIOD=2; commit CTRL with auto_en=1 -> effect sequence over successive frames: 0x01,0x01,0x02,0x02,0x04,0x04,0x10,0x10,0x01.
- Commit request in the same cycle as frame_start -> no change that cycle; applies at the next SOP. STATUS[0] reads 1 in between.
- Drop reset to 0 during PENDING in AUTO -> all outputs 0 asynchronously, STATUS reads 0 after release, and the next SOP applies nothing.
- Read address 6 -> 0. Write address 15 -> no register changes. Readback CTRL after a commit write -> bit 31=0.
